fft_index_gen: RTL and testbench

//  Address/control sequencer feeding the FFT butterfly datapath. On a start pulse it walks all FFT_N

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_twiddle_addr.sv | 14 +
 rtl/fft_index_gen.sv | 171 +++++++++++++++++
 tb/tb_fft_index_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT address/control sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fft_seq_state_t;

  localparam int unsigned CTRL_W       = 2;
  localparam int unsigned CTRL_SOF_BIT = 0;
  localparam int unsigned CTRL_EOF_BIT = 1;
  localparam int unsigned FFT_STAGE_W  = 4;

endpackage

// File: rtl/fft_twiddle_addr.sv
// Constant-geometry DIF twiddle index: low s bits of the pair index are cleared.
module fft_twiddle_addr
  import fft_pkg::*;
#(
  parameter int unsigned FFT_N = 10
) (
  input  logic [FFT_N-2:0]       k_i,
  input  logic [FFT_STAGE_W-1:0] stage_i,
  output logic [FFT_N-2:0]       tw_addr_c_o
);

  assign tw_addr_c_o = (k_i >> stage_i) << stage_i;

endmodule

// File: rtl/fft_index_gen.sv
// Butterfly address/control sequencer: walks FFT_N radix-2 stages with a drain gap after each.
// Optional stall input enabled by defining FFT_INDEX_GEN_HOLD_EN.
module fft_index_gen
  import fft_pkg::*;
#(
  parameter int unsigned FFT_N     = 10,
  parameter int unsigned DRAIN_CYC = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   hold_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   act_o,
  output logic [CTRL_W-1:0]      ctrl_o,
  output logic [FFT_N-2:0]       mem_addr_o,
  output logic [FFT_N-2:0]       tw_addr_o,
  output logic                   even_odd_o,
  output logic [FFT_STAGE_W-1:0] stage_o
);

  localparam int unsigned AW = FFT_N - 1;
  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);
  localparam logic [AW-1:0]          K_LAST = '1;
  localparam logic [DW-1:0]          D_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [FFT_STAGE_W-1:0] S_LAST = FFT_STAGE_W'(FFT_N - 1);

  fft_seq_state_t state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [FFT_STAGE_W-1:0] s_q, s_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   act_q, act_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [AW-1:0]          mem_q, mem_d;
  logic [AW-1:0]          tw_q, tw_d;
  logic [FFT_STAGE_W-1:0] so_q, so_d;
  logic                   eo_q, eo_d;

  logic                   stall_c;
  logic                   beat_c;
  logic [AW-1:0]          tw_c;

`ifdef FFT_INDEX_GEN_HOLD_EN
  assign stall_c = hold_i;
`else
  logic unused_hold_c;
  assign unused_hold_c = hold_i;
  assign stall_c       = 1'b0;
`endif

  assign beat_c = (state_q == RUN) && !stall_c;

  fft_twiddle_addr #(
    .FFT_N(FFT_N)
  ) u_twiddle (
    .k_i         (k_q),
    .stage_i     (s_q),
    .tw_addr_c_o (tw_c)
  );

  // Next-state and next-output logic; outputs lag the sequencer state by one cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    s_d     = s_q;
    busy_d  = (state_q == RUN) || (state_q == DRAIN);
    done_d  = (state_q == DONE);
    act_d   = beat_c;
    ctrl_d  = '0;
    mem_d   = mem_q;
    tw_d    = tw_q;
    so_d    = so_q;
    eo_d    = eo_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          k_d     = '0;
          drain_d = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        if (!stall_c) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          drain_d = '0;
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + FFT_STAGE_W'(1);
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Address/stage outputs only move on an issued beat so they hold through drain and stalls.
    if (beat_c) begin
      ctrl_d[CTRL_SOF_BIT] = (s_q == '0) && (k_q == '0);
      ctrl_d[CTRL_EOF_BIT] = (s_q == S_LAST) && (k_q == K_LAST);
      mem_d                = k_q;
      tw_d                 = tw_c;
      so_d                 = s_q;
      eo_d                 = s_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      act_q   <= 1'b0;
      ctrl_q  <= '0;
      mem_q   <= '0;
      tw_q    <= '0;
      so_q    <= '0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      act_q   <= act_d;
      ctrl_q  <= ctrl_d;
      mem_q   <= mem_d;
      tw_q    <= tw_d;
      so_q    <= so_d;
      eo_q    <= eo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign act_o      = act_q;
  assign ctrl_o     = ctrl_q;
  assign mem_addr_o = mem_q;
  assign tw_addr_o  = tw_q;
  assign even_odd_o = eo_q;
  assign stage_o    = so_q;

endmodule

// File: tb/tb_fft_index_gen.sv
// Self-checking bench for fft_index_gen (FFT_N=4, DRAIN_CYC=3) against a position-based frame model.
module tb_fft_index_gen;

  localparam int FN    = 4;
  localparam int DC    = 3;
  localparam int H     = 8;
  localparam int PER   = H + DC;
  localparam int TOTAL = FN * PER;
`ifdef FFT_INDEX_GEN_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_i, start_i, hold_i;
  logic       busy_o, done_o, act_o, even_odd_o;
  logic [1:0] ctrl_o;
  logic [2:0] mem_addr_o, tw_addr_o;
  logic [3:0] stage_o;

  int checks = 0;
  int errors = 0;

  // model state: position within the frame, advanced by the frame rules only
  bit   m_on;
  int   m_pos;
  logic e_busy, e_done, e_act, e_eo;
  logic [1:0] e_ctrl;
  logic [2:0] e_mem, e_tw;
  logic [3:0] e_stage;

  fft_index_gen #(
    .FFT_N     (FN),
    .DRAIN_CYC (DC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .hold_i     (hold_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .act_o      (act_o),
    .ctrl_o     (ctrl_o),
    .mem_addr_o (mem_addr_o),
    .tw_addr_o  (tw_addr_o),
    .even_odd_o (even_odd_o),
    .stage_o    (stage_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit h, input bit r);
    int pn, rr, kk, ss;
    e_done = 1'b0;
    e_act  = 1'b0;
    e_ctrl = 2'b00;
    if (r) begin
      m_on = 1'b0; e_busy = 1'b0;
      e_mem = '0; e_tw = '0; e_stage = '0; e_eo = 1'b0;
    end else if (!m_on) begin
      e_busy = 1'b0;
      if (s) begin
        m_on  = 1'b1;
        m_pos = -1;
      end
    end else begin
      pn = m_pos + 1;
      if (pn == TOTAL) begin
        e_done = 1'b1; e_busy = 1'b0; m_on = 1'b0;
      end else begin
        e_busy = 1'b1;
        rr = pn % PER;
        if (rr < H) begin
          if (!(HOLD_EN && h)) begin
            m_pos   = pn;
            kk      = rr;
            ss      = pn / PER;
            e_act   = 1'b1;
            e_mem   = 3'(kk);
            e_tw    = 3'((kk >> ss) << ss);
            e_stage = 4'(ss);
            e_eo    = 1'(ss % 2);
            e_ctrl  = {(ss == FN - 1 && kk == H - 1), (ss == 0 && kk == 0)};
          end
        end else begin
          m_pos = pn;
        end
      end
    end
  endtask

  // one clock: drive at negedge, model the edge, check at the following negedge
  task automatic cyc(input bit s, input bit h, input bit r);
    start_i = s; hold_i = h; rst_i = r;
    model_step(s, h, r);
    @(posedge clk);
    @(negedge clk);
    chk("busy", 16'(busy_o), 16'(e_busy));
    chk("done", 16'(done_o), 16'(e_done));
    chk("act", 16'(act_o), 16'(e_act));
    chk("ctrl", 16'(ctrl_o), 16'(e_ctrl));
    chk("mem_addr", 16'(mem_addr_o), 16'(e_mem));
    chk("tw_addr", 16'(tw_addr_o), 16'(e_tw));
    chk("stage", 16'(stage_o), 16'(e_stage));
    chk("even_odd", 16'(even_odd_o), 16'(e_eo));
  endtask

  task automatic frame(input bit spurious, input int hold_at, input int rst_at,
                       input bit rnd_hold, input int exp_len);
    int  first, done_c, hold_left, cnt;
    bit  fin, hold_used, s, h, r;
    first = -1; done_c = -1; hold_left = 0; cnt = 0; fin = 1'b0; hold_used = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    while (!fin && cnt < 2000) begin
      s = spurious && ($urandom_range(0, 3) == 0);
      r = (rst_at >= 0) && m_on && (m_pos == rst_at);
      if (hold_at >= 0 && !hold_used && m_on && m_pos == hold_at) begin
        hold_left = 5;
        hold_used = 1'b1;
      end
      h = (hold_left > 0) || (rnd_hold && $urandom_range(0, 3) == 0);
      if (hold_left > 0) hold_left--;
      cyc(s, h, r);
      cnt++;
      if (act_o && first < 0) first = cnt;
      if (done_o) begin done_c = cnt; fin = 1'b1; end
      if (r) fin = 1'b1;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL frame_timeout: observed no done after %0d cycles, expected done", cnt);
    end else if (exp_len > 0) begin
      chk("frame_len", 16'(done_c - first), 16'(exp_len));
    end
  endtask

  initial begin
    start_i = 1'b0; hold_i = 1'b0; rst_i = 1'b1;
    m_on = 1'b0; m_pos = -1;
    @(negedge clk);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    // start together with reset must be dropped
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    // full frame with stray start pulses while busy
    frame(1'b1, -1, -1, 1'b0, TOTAL);
    // back-to-back start in the cycle after done
    frame(1'b0, -1, -1, 1'b0, TOTAL);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    // abort at stage 1, k=3, then idle cycles with no done
    frame(1'b0, PER + 3, -1, 1'b0, 0);
    frame(1'b0, -1, PER + 3, 1'b0, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    frame(1'b0, -1, -1, 1'b0, TOTAL);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    // 5-cycle hold starting at beat k=5 of stage 0
    frame(1'b0, 4, -1, 1'b0, HOLD_EN ? TOTAL + 5 : TOTAL);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    // random holds and stray starts throughout a frame
    frame(1'b1, -1, -1, 1'b1, 0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
